// File: rtl/upordown_counter_pkg.sv
// Shared types and default constants for the up/down counter slice.
package upordown_counter_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } run_state_e;

  localparam int COUNT_W = 7;

  localparam int DEF_MAX_COUNT  = 99;
  localparam int DEF_LOAD_VALUE = 50;
  localparam int DEF_BUZ_LEN    = 4;
  localparam int DEF_TICK_DIV   = 1;

endpackage

// File: rtl/upordown_counter_tick.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick
// combinationally on the cycle it wraps, so TICK_DIV=1 ticks every enabled edge.
module upordown_tick #(
  parameter int TICK_DIV = 1
) (
  input  logic Clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] div_q, div_d;

  assign tick = enable && !clear && (div_q == LAST);

  always_comb begin
    div_d = div_q;
    if (clear) begin
      div_d = '0;
    end else if (enable) begin
      div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/upordown_counter.sv
// Wrapping up/down counter with start/stop run FSM, preset load and a
// buzzer pulse of BUZ_LEN cycles on every wrap.
module upordown_counter
  import upordown_counter_pkg::*;
#(
  parameter int MAX_COUNT  = DEF_MAX_COUNT,
  parameter int LOAD_VALUE = DEF_LOAD_VALUE,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int BUZ_LEN    = DEF_BUZ_LEN
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               UpOrDown,
  input  logic               load,
  input  logic               stop,
  input  logic               start,
  output logic [COUNT_W-1:0] Count,
  output logic               buz
);

  localparam int BT_W = $clog2(BUZ_LEN + 1);
  localparam logic [COUNT_W-1:0] MAX_C  = COUNT_W'(MAX_COUNT);
  localparam logic [COUNT_W-1:0] LOAD_C = COUNT_W'(LOAD_VALUE);
  localparam logic [BT_W-1:0]    BUZ_C  = BT_W'(BUZ_LEN);

  run_state_e         state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [BT_W-1:0]    buz_tmr_q, buz_tmr_d;
  logic               buz_q, buz_d;
  logic               tick, wrap, running;

  assign running = (state_q == RUNNING);

  upordown_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .Clk    (Clk),
    .reset  (reset),
    .enable (running),
    .clear  (load),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = STOPPED;
    end else if (start) begin
      state_d = RUNNING;
    end
  end

  always_comb begin
    count_d = count_q;
    wrap    = 1'b0;
    if (load) begin
      count_d = LOAD_C;
    end else if (tick) begin
      if (UpOrDown) begin
        if (count_q == '0) begin
          count_d = MAX_C;
          wrap    = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end else begin
        if (count_q >= MAX_C) begin
          count_d = '0;
          wrap    = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end
  end

  // Timer is loaded with the full length on wrap so buz rises with the wrapped Count.
  always_comb begin
    buz_tmr_d = buz_tmr_q;
    if (load) begin
      buz_tmr_d = '0;
    end else if (wrap) begin
      buz_tmr_d = BUZ_C;
    end else if (buz_tmr_q != '0) begin
      buz_tmr_d = buz_tmr_q - 1'b1;
    end
    buz_d = (buz_tmr_d != '0);
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q   <= STOPPED;
      count_q   <= '0;
      buz_tmr_q <= '0;
      buz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      buz_tmr_q <= buz_tmr_d;
      buz_q     <= buz_d;
    end
  end

  assign Count = count_q;
  assign buz   = buz_q;

endmodule

// File: tb/tb_upordown_counter.sv
// Directed bench for upordown_counter with default parameters.
module tb_upordown_counter;

  logic       Clk;
  logic       reset;
  logic       UpOrDown;
  logic       load;
  logic       stop;
  logic       start;
  logic [6:0] Count;
  logic       buz;

  int unsigned n_chk;
  int unsigned n_bad;

  upordown_counter #(
    .MAX_COUNT  (99),
    .LOAD_VALUE (50),
    .TICK_DIV   (1),
    .BUZ_LEN    (4)
  ) dut (
    .Clk      (Clk),
    .reset    (reset),
    .UpOrDown (UpOrDown),
    .load     (load),
    .stop     (stop),
    .start    (start),
    .Count    (Count),
    .buz      (buz)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_cb(input string tag, input int unsigned c, input int unsigned b);
    check({tag, ".count"}, Count, c);
    check({tag, ".buz"}, buz, b);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b0; UpOrDown = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0;
    step();
    step();
    chk_cb("reset", 0, 0);

    reset = 1'b1; start = 1'b1;
    step();
    chk_cb("enter_run", 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_cb("up_first", i, 0);
    end

    for (int i = 4; i <= 97; i++) step();
    check("at97", Count, 97);
    step(); chk_cb("up98", 98, 0);
    step(); chk_cb("up99", 99, 0);
    step(); chk_cb("wrap_up", 0, 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_cb("buz_hold", i, 1);
    end
    step(); chk_cb("buz_end", 4, 0);

    for (int i = 5; i <= 9; i++) step();
    check("at9", Count, 9);
    stop = 1'b1;
    step(); chk_cb("stop_edge", 10, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("stopped_hold", Count, 10);
    end
    stop = 1'b0; start = 1'b1;
    step(); check("restart_edge", Count, 10);
    step(); check("restart_step", Count, 11);
    start = 1'b0;

    reset = 1'b0;
    step(); chk_cb("reset2", 0, 0);
    reset = 1'b1; start = 1'b1;
    step(); check("enter_run2", Count, 0);
    start = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    check("at7", Count, 7);
    load = 1'b1;
    step(); chk_cb("load", 50, 0);
    load = 1'b0; UpOrDown = 1'b1;
    step(); check("down49", Count, 49);
    step(); check("down48", Count, 48);

    for (int i = 47; i >= 1; i--) step();
    check("at1", Count, 1);
    step(); chk_cb("down0", 0, 0);
    step(); chk_cb("wrap_down", 99, 1);
    step(); chk_cb("down98", 98, 1);
    reset = 1'b0;
    step(); chk_cb("reset_midpulse", 0, 0);

    reset = 1'b1; start = 1'b1; stop = 1'b1;
    step(); check("both_edge", Count, 0);
    step(); check("both_hold", Count, 0);
    stop = 1'b0;
    step(); check("enter_run3", Count, 0);
    start = 1'b0;
    step(); chk_cb("wrap_a", 99, 1);
    UpOrDown = 1'b0;
    step(); chk_cb("wrap_b", 0, 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_cb("restart_buz", i, 1);
    end
    step(); chk_cb("restart_buz_end", 4, 0);
    start = 1'b1; stop = 1'b1;
    step(); check("both_run_edge", Count, 5);
    step(); check("both_run_hold", Count, 5);
    start = 1'b0; stop = 1'b0;
    load = 1'b1; reset = 1'b0;
    step(); chk_cb("load_vs_reset", 0, 0);
    load = 1'b0; reset = 1'b1;
    step(); check("post_reset_stopped", Count, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/upordown_counter.md
UPORDOWN_COUNTER -- requirements
Module: upordown

Interface
REQ-001 Parameter MAX_COUNT, default 99, terminal (highest) count value.
REQ-002 Parameter LOAD_VALUE, default 50, preset value applied by load; SHALL satisfy LOAD_VALUE <= MAX_COUNT.
REQ-003 Parameter TICK_DIV, default 1, clock cycles per count step (1 = step every cycle).
REQ-004 Parameter BUZ_LEN, default 4, buzzer pulse length in clock cycles.
REQ-005 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-007 UpOrDown  input  1  direction: 0 = count up, 1 = count down.
REQ-008 load  input  1  synchronous preset of Count to LOAD_VALUE.
REQ-009 stop  input  1  level request to halt counting.
REQ-010 start  input  1  level request to run counting.
REQ-011 Count  output  7  current count, registered, range 0..MAX_COUNT.
REQ-012 buz  output  1  registered buzzer, high for BUZ_LEN cycles after each wrap.

Function
REQ-013 Run FSM SHALL have two states: STOPPED and RUNNING.
REQ-014 Transitions: stop=1 -> STOPPED (stop wins when start=1 too); start=1 with stop=0 -> RUNNING; otherwise hold state.
REQ-015 The FSM transition SHALL occur at the edge where the inputs are sampled; counting starts or stops from the next edge.
REQ-016 Prescaler: counts 0..TICK_DIV-1 in RUNNING only, holds in STOPPED; a step tick fires when it wraps.
REQ-017 Per-edge priority: reset, then load, then step tick, then hold.
REQ-018 load=1: Count <= LOAD_VALUE and prescaler <= 0, in either FSM state; FSM state unchanged; buz cleared.
REQ-019 Up tick: Count < MAX_COUNT -> Count+1; Count = MAX_COUNT -> 0 (wrap event).
REQ-020 Down tick: Count > 0 -> Count-1; Count = 0 -> MAX_COUNT (wrap event).
REQ-021 Direction changes on UpOrDown take effect at the next tick with no extra latency.
REQ-022 Wrap event: buz SHALL rise in the same edge as the wrapped Count and stay high BUZ_LEN cycles.
REQ-023 A new wrap while buz is high SHALL restart the full BUZ_LEN period.
REQ-024 In STOPPED, Count and prescaler SHALL hold; the buz timer keeps counting down to completion.
REQ-025 Count arithmetic SHALL be 7-bit unsigned; no value outside 0..MAX_COUNT SHALL ever appear.

Reset
REQ-026 While reset=0 at a rising edge: Count=0, buz=0, FSM=STOPPED, prescaler=0, buz timer=0.
REQ-027 Reset overrides load, start and stop; reset asserted mid-run SHALL take effect at that edge.
REQ-028 After release, the first start=1 (stop=0) edge enters RUNNING; the first step follows TICK_DIV edges later.

Structure
REQ-029 The following SHALL live in a shared package:
- FSM state typedef (STOPPED, RUNNING)
- COUNT_W=7 constant
- default constants MAX_COUNT, LOAD_VALUE, BUZ_LEN
REQ-030 One sub-module, upordown_tick, SHALL implement the TICK_DIV prescaler:
- inputs: Clk, reset, enable, clear
- output: tick
REQ-031 The top level SHALL contain the FSM, the counter register and the buzzer timer.

Verification (TICK_DIV=1, defaults)
REQ-032 reset=0 for 2 edges -> Count=0, buz=0; release, start=1, UpOrDown=0 -> Count 1,2,3 on successive edges.
REQ-033 Running up from 97 -> Count 98, 99, 0; buz=1 at the edge Count becomes 0 and stays high exactly 4 cycles.
REQ-034 Count=10 running, stop=1 start=0 for 12 cycles -> Count stays 10; start=1 stop=0 -> 11 on the next step edge.
REQ-035 load=1 one cycle while Count=7 -> Count=50 next edge; then UpOrDown=1 -> 49, 48.
REQ-036 Down from 1 -> 0 then 99 with a buz pulse; reset=0 mid-pulse -> Count=0, buz=0 at that edge.
REQ-037 start=1 and stop=1 together -> STOPPED, Count holds; load=1 and reset=0 together -> Count=0.
